// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : datapath_pkg
//  Purpose  : Shared ALU opcode encodings for the pipelined datapath
//  Revision : 1.0  initial release
// ============================================================================
package datapath_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [OP_W-1:0] ALU_XOR = 3'b011;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b100;
  localparam logic [OP_W-1:0] ALU_SLT = 3'b101;
  localparam logic [OP_W-1:0] ALU_SLL = 3'b110;
  localparam logic [OP_W-1:0] ALU_SRL = 3'b111;

endpackage
`default_nettype wire

// File: rtl/alu_param.sv
`default_nettype none
// ============================================================================
//  Module   : alu_param
//  Purpose  : Combinational 8-op ALU with zero/carry/overflow status
//  Revision : 1.0  initial release
// ============================================================================
module alu_param
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int SW = $clog2(WIDTH);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SW-1:0]    w_shamt;

  // The extra top bit of the subtraction is the unsigned borrow (A < B).
  assign w_sum   = {1'b0, a_i} + {1'b0, b_i};
  assign w_diff  = {1'b0, a_i} - {1'b0, b_i};
  assign w_shamt = b_i[SW-1:0];

  // Operation select and flag generation
  always_comb begin
    result_o   = '0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    case (op_i)
      ALU_ADD: begin
        result_o   = w_sum[WIDTH-1:0];
        carry_o    = w_sum[WIDTH];
        overflow_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (w_sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_SUB: begin
        result_o   = w_diff[WIDTH-1:0];
        carry_o    = w_diff[WIDTH];
        overflow_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (w_diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLL: result_o = a_i << w_shamt;
      ALU_SRL: result_o = a_i >> w_shamt;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule
`default_nettype wire

// File: rtl/pipelined_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_datapath
//  Purpose  : NREGS x WIDTH register file + ALU, 2-stage pipeline with full
//             forwarding, priority load port and debug read port
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_datapath
  import datapath_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             wr,
  input  logic [AW-1:0]    addr1,
  input  logic [AW-1:0]    addr2,
  input  logic [AW-1:0]    addr3,
  input  logic [OP_W-1:0]  ALUControl,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs_q [NREGS];

  // Stage E pipeline registers
  logic             e_valid_q;
  logic             e_wr_q;
  logic [OP_W-1:0]  e_op_q;
  logic [AW-1:0]    e_dst_q;
  logic [WIDTH-1:0] e_a_q;
  logic [WIDTH-1:0] e_b_q;

  // Stage W registers
  logic [WIDTH-1:0] result_q;
  logic             out_valid_q;
  logic             zero_q;
  logic             carry_q;
  logic             overflow_q;

  logic [WIDTH-1:0] opa_d;
  logic [WIDTH-1:0] opb_d;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_ovf;
  logic             wb_en;

  assign wb_en = e_valid_q && e_wr_q;

  alu_param #(.WIDTH(WIDTH)) u_alu (
    .op_i       (e_op_q),
    .a_i        (e_a_q),
    .b_i        (e_b_q),
    .result_o   (alu_res),
    .zero_o     (alu_zero),
    .carry_o    (alu_carry),
    .overflow_o (alu_ovf)
  );

  // Operand bypass: same-edge load beats in-flight writeback beats regfile
  always_comb begin
    opa_d = regs_q[addr1];
    opb_d = regs_q[addr2];
    if (load_en && load_addr == addr1) opa_d = load_data;
    else if (wb_en && e_dst_q == addr1) opa_d = alu_res;
    if (load_en && load_addr == addr2) opb_d = load_data;
    else if (wb_en && e_dst_q == addr2) opb_d = alu_res;
  end

  // Stage E: capture the issued instruction with its forwarded operands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_valid_q <= 1'b0;
      e_wr_q    <= 1'b0;
      e_op_q    <= '0;
      e_dst_q   <= '0;
      e_a_q     <= '0;
      e_b_q     <= '0;
    end else begin
      e_valid_q <= in_valid;
      if (in_valid) begin
        e_wr_q  <= wr;
        e_op_q  <= ALUControl;
        e_dst_q <= addr3;
        e_a_q   <= opa_d;
        e_b_q   <= opb_d;
      end
    end
  end

  // Stage W: register result/flags; they hold while no instruction retires
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= e_valid_q;
      if (e_valid_q) begin
        result_q   <= alu_res;
        zero_q     <= alu_zero;
        carry_q    <= alu_carry;
        overflow_q <= alu_ovf;
      end
    end
  end

  // Register file: load port has priority over a writeback to the same entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (load_en && load_addr == AW'(i)) regs_q[i] <= load_data;
        else if (wb_en && e_dst_q == AW'(i)) regs_q[i] <= alu_res;
      end
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign dbg_data  = regs_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_datapath
//  Purpose  : Directed self-checking bench, 32x4 and 16x8 configurations
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_datapath;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 32-bit / 4-register instance
  logic        in_valid = 0, wr = 0, load_en = 0;
  logic [1:0]  addr1 = 0, addr2 = 0, addr3 = 0, load_addr = 0, dbg_addr = 0;
  logic [2:0]  ALUControl = 0;
  logic [31:0] load_data = 0, result, dbg_data;
  logic        out_valid, zero, carry, overflow;

  pipelined_datapath #(.WIDTH(32), .NREGS(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .wr(wr),
    .addr1(addr1), .addr2(addr2), .addr3(addr3), .ALUControl(ALUControl),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .result(result), .out_valid(out_valid), .zero(zero), .carry(carry),
    .overflow(overflow), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // 16-bit / 8-register instance
  logic        b_in_valid = 0, b_wr = 0, b_load_en = 0;
  logic [2:0]  b_addr1 = 0, b_addr2 = 0, b_addr3 = 0, b_load_addr = 0, b_dbg_addr = 0;
  logic [2:0]  b_op = 0;
  logic [15:0] b_load_data = 0, b_result, b_dbg_data;
  logic        b_out_valid, b_zero, b_carry, b_overflow;

  pipelined_datapath #(.WIDTH(16), .NREGS(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .wr(b_wr),
    .addr1(b_addr1), .addr2(b_addr2), .addr3(b_addr3), .ALUControl(b_op),
    .load_en(b_load_en), .load_addr(b_load_addr), .load_data(b_load_data),
    .result(b_result), .out_valid(b_out_valid), .zero(b_zero), .carry(b_carry),
    .overflow(b_overflow), .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data)
  );

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, XOR_ = 3'b011;
  localparam logic [2:0] SLT = 3'b101, SLL = 3'b110, SRL = 3'b111;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    in_valid = 0; wr = 0; load_en = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic w,
                       input logic [1:0] a1, input logic [1:0] a2, input logic [1:0] a3);
    in_valid = 1; ALUControl = op; wr = w; addr1 = a1; addr2 = a2; addr3 = a3;
  endtask

  task automatic load(input logic [1:0] a, input logic [31:0] d);
    load_en = 1; load_addr = a; load_data = d;
  endtask

  task automatic b_issue(input logic [2:0] op, input logic [2:0] a1,
                         input logic [2:0] a2, input logic [2:0] a3);
    b_in_valid = 1; b_op = op; b_wr = 1; b_addr1 = a1; b_addr2 = a2; b_addr3 = a3;
  endtask

  task automatic test_reset();
    rst = 0;
    tick(); tick();
    rst = 1;
    tick();
    load(1, 32'd5);
    tick();
    quiet();
    issue(ADD, 1, 1, 1, 0);
    tick();
    // ADD now sits in stage E; reset asynchronously with in_valid still high
    rst = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b result=%h, want 0/0", out_valid, result);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      checks++;
      if (dbg_data !== 32'd0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h want 0", i, dbg_data);
      end
    end
    tick();
    quiet();
    rst = 1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_release_idle: out_valid=%b result=%h, want 0/0", out_valid, result);
    end
  endtask

  task automatic test_load_add();
    load(1, 32'd5); tick();
    load(2, 32'd7); tick();
    load(3, 32'd3); tick();
    quiet();
    issue(ADD, 1, 1, 2, 0);
    tick();
    quiet();
    tick();
    dbg_addr = 0;
    #1;
    checks++;
    if (result !== 32'd12 || out_valid !== 1'b1 || zero !== 1'b0 || dbg_data !== 32'd12) begin
      errors++;
      $display("FAIL add: result=%h ov=%b z=%b R0=%h, want 0000000c/1/0/0000000c",
               result, out_valid, zero, dbg_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || result !== 32'd12) begin
      errors++;
      $display("FAIL hold: out_valid=%b result=%h, want 0/0000000c", out_valid, result);
    end
  endtask

  task automatic test_back_to_back();
    issue(AND_, 1, 2, 3, 1);   // R1 = 7 & 3 = 3
    tick();
    issue(XOR_, 1, 1, 0, 3);   // R3 = R1 ^ R0 = 3 ^ 12 = 15, R1 forwarded
    tick();
    checks++;
    if (result !== 32'd3 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: result=%h ov=%b, want 00000003/1", result, out_valid);
    end
    quiet();
    tick();
    dbg_addr = 3;
    #1;
    checks++;
    if (result !== 32'd15 || out_valid !== 1'b1 || dbg_data !== 32'd15) begin
      errors++;
      $display("FAIL b2b_second: result=%h ov=%b R3=%h, want 0000000f/1/0000000f",
               result, out_valid, dbg_data);
    end
  endtask

  task automatic test_sub();
    issue(SUB, 1, 1, 3, 2);    // R2 = 3 - 15
    tick();
    issue(SUB, 1, 2, 2, 0);    // R0 = R2 - R2 (both forwarded)
    tick();
    checks++;
    if (result !== 32'hFFFF_FFF4 || carry !== 1'b1 || overflow !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: result=%h c=%b v=%b z=%b, want fffffff4/1/0/0",
               result, carry, overflow, zero);
    end
    quiet();
    tick();
    checks++;
    if (result !== 32'd0 || zero !== 1'b1 || carry !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL sub_zero: result=%h z=%b c=%b v=%b, want 0/1/0/0",
               result, zero, carry, overflow);
    end
  endtask

  task automatic test_overflow_shift_slt();
    load(0, 32'h7FFF_FFFF); tick();
    load(1, 32'd1); tick();
    quiet();
    issue(ADD, 0, 0, 1, 2);    // no writeback
    tick();
    issue(SLL, 1, 1, 1, 3);    // R3 = 1 << 1
    tick();
    dbg_addr = 2;
    #1;
    checks++;
    if (result !== 32'h8000_0000 || overflow !== 1'b1 || carry !== 1'b0 || dbg_data !== 32'hFFFF_FFF4) begin
      errors++;
      $display("FAIL add_ovf: result=%h v=%b c=%b R2=%h, want 80000000/1/0/fffffff4",
               result, overflow, carry, dbg_data);
    end
    issue(SLT, 1, 2, 1, 0);    // 0xFFFFFFF4 (-12) < 1 signed
    tick();
    checks++;
    if (result !== 32'd2 || zero !== 1'b0) begin
      errors++;
      $display("FAIL sll: result=%h z=%b, want 00000002/0", result, zero);
    end
    quiet();
    tick();
    checks++;
    if (result !== 32'd1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL slt: result=%h ov=%b, want 00000001/1", result, out_valid);
    end
  endtask

  task automatic test_load_collision();
    issue(ADD, 1, 1, 1, 3);    // R3 <- 2 pending
    tick();
    quiet();
    load(3, 32'hAA);
    tick();
    dbg_addr = 3;
    #1;
    checks++;
    if (dbg_data !== 32'hAA || result !== 32'd2 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL load_wins: R3=%h result=%h ov=%b, want 000000aa/00000002/1",
               dbg_data, result, out_valid);
    end
    issue(ADD, 1, 1, 1, 2);    // R2 <- 2 pending
    tick();
    quiet();
    load(0, 32'h55);
    tick();
    quiet();
    dbg_addr = 2;
    #1;
    checks++;
    if (dbg_data !== 32'd2) begin
      errors++;
      $display("FAIL wb_other_addr: R2=%h want 00000002", dbg_data);
    end
    dbg_addr = 0;
    #1;
    checks++;
    if (dbg_data !== 32'h55) begin
      errors++;
      $display("FAIL load_other_addr: R0=%h want 00000055", dbg_data);
    end
    // Same-cycle load of a source register feeds the issued instruction
    issue(ADD, 1, 0, 0, 1);
    load(0, 32'd9);
    tick();
    quiet();
    tick();
    checks++;
    if (result !== 32'd18) begin
      errors++;
      $display("FAIL load_bypass: result=%h want 00000012", result);
    end
  endtask

  task automatic test_wide();
    b_load_en = 1; b_load_addr = 5; b_load_data = 16'h7FFF; tick();
    b_load_addr = 6; b_load_data = 16'h0001; tick();
    b_load_addr = 4; b_load_data = 16'h0011; tick();
    b_load_en = 0;
    b_issue(ADD, 5, 6, 7);     // R7 = 0x8000
    tick();
    b_issue(SRL, 7, 6, 7);     // R7 = R7 >> 1, forwarded
    tick();
    checks++;
    if (b_result !== 16'h8000 || b_overflow !== 1'b1 || b_carry !== 1'b0 || b_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL w16_add_ovf: result=%h v=%b c=%b ov=%b, want 8000/1/0/1",
               b_result, b_overflow, b_carry, b_out_valid);
    end
    b_issue(SLL, 6, 4, 3);     // shift amount 0x11 -> low 4 bits = 1
    tick();
    checks++;
    if (b_result !== 16'h4000) begin
      errors++;
      $display("FAIL w16_srl: result=%h want 4000", b_result);
    end
    b_in_valid = 0; b_wr = 0;
    tick();
    b_dbg_addr = 7;
    #1;
    checks++;
    if (b_result !== 16'h0002 || b_dbg_data !== 16'h4000) begin
      errors++;
      $display("FAIL w16_sll_mask: result=%h R7=%h, want 0002/4000", b_result, b_dbg_data);
    end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_back_to_back();
    test_sub();
    test_overflow_shift_slt();
    test_load_collision();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_datapath.md
Name: pipelined_datapath

Overview:
Parametrised successor to the 4x32 register-file + ALU datapath. It has NREGS registers of WIDTH bits and an 8-op ALU with status flags. A 2-stage pipeline (read/latch, execute/writeback) with full result forwarding accepts one instruction per cycle without stalls. A priority load port initialises registers, and a debug read port supports verification.

Parameters:
WIDTH, 32, datapath and register width (>=8)
NREGS, 4, register count (power of 2, >=2)
AW, $clog2(NREGS), register address width (derived, localparam)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  instruction present this cycle
wr  in  1  write result to addr3
addr1  in  AW  source A register
addr2  in  AW  source B register
addr3  in  AW  destination register
ALUControl  in  3  op code
load_en  in  1  external register write
load_addr  in  AW  load target
load_data  in  WIDTH  load value
result  out  WIDTH  registered ALU result
out_valid  out  1  one-cycle pulse, result/flags valid
zero  out  1  result == 0
carry  out  1  ADD carry-out / SUB borrow
overflow  out  1  signed overflow (ADD/SUB only)
dbg_addr  in  AW  debug read address
dbg_data  out  WIDTH  combinational regfile read, no bypass

Behaviour:
- Reset (rst=0, async): all registers, result, flags, out_valid and internal stage-E valid are 0. In-flight instruction is discarded. All inputs are ignored while rst=0.
- ALUControl: 000 ADD, 001 SUB (A-B), 010 AND, 011 XOR, 100 OR, 101 SLT (signed, result 0/1), 110 SLL, 111 SRL. Shift amount = B[$clog2(WIDTH)-1:0]; upper bits are ignored.
- Stage E: at a rising edge with in_valid=1, latch op, wr, addr3, and operands A and B. Without in_valid, stage-E valid clears.
- Operand read uses a bypass with this priority:
  1. load_en && load_addr==addrX -> load_data
  2. E valid && E wr && E dst==addrX -> ALU output (combinational)
  3. regfile[addrX]
- Stage W: at the next edge after E is valid: result, flags and out_valid=1 register. If E wr=1, regfile[E dst] <= ALU output on the same edge.
- Latency: issue at edge k -> result/out_valid visible after edge k+1; dependent back-to-back issue sees the correct value.
- Throughput: 1 instruction/cycle, no backpressure.
- out_valid=0 cycles: result and flags hold their last value.
- Load port: regfile[load_addr] <= load_data at any edge. If it collides with a writeback to the same address on the same edge, load wins. A writeback to a different address commits normally.
- Flags:
  - zero = (result==0) for all ops.
  - carry = bit WIDTH of a (WIDTH+1)-bit add for ADD; 1 iff A<B unsigned for SUB; 0 otherwise.
  - overflow = signed overflow for ADD/SUB; 0 otherwise.
- wr=0: result and flags are still produced; no register changes.
- dbg_data reflects committed state only (post-edge).

Decomposition:
- datapath_pkg: ALU op localparams (ALU_ADD..ALU_SRL), op width 3.
- Sub-module alu_param (WIDTH): combinational op -> result, zero, carry, overflow. Instantiated once in stage E.
- Regfile, bypass and pipeline registers stay in pipelined_datapath.

Test Plan:
1. Assert rst=0 while an ADD is in E -> out_valid=0, result=0, all dbg reads 0; release, next cycle idle out_valid=0.
2. Load R1=5, R2=7, R3=3, then issue R0<-R1+R2 (000) -> one cycle later result=12, out_valid=1, zero=0; dbg R0=12.
3. Back-to-back: R1<-R2 AND R3 then R3<-R1 XOR R0 on consecutive cycles -> results 3 then 15 on consecutive cycles (forwarded R1); dbg R3=15.
4. R2<-R1 SUB R3 (3-15) -> result=0xFFFFFFF4, carry=1, overflow=0, zero=0. Then R0<-R2 SUB R2 -> 0, zero=1.
5. Load R0=0x7FFFFFFF, R1=1, ADD wr=0 into R2 -> result=0x80000000, overflow=1, carry=0; dbg R2 unchanged. SLL R1 by R1 -> 2; SLT R2,R1 -> 1.
6. In the same cycle as a pending writeback to R3, load_en R3=0xAA -> dbg R3=0xAA. Repeat the suite with NREGS=8, WIDTH=16 (0x7FFF+1 -> 0x8000, overflow=1).
